// File: rtl/fp_issue_ctrl_pkg.sv
// Shared definitions for the FP issue controller: op-bit positions, rounding
// mode encodings, exception flag positions, FSM encoding and small helpers.
package fp_issue_ctrl_pkg;

  localparam int OP_W = 17;

  // Bit positions inside the 17-bit decoded op vector
  localparam int OP_FMADD    = 16;
  localparam int OP_FMSUB    = 15;
  localparam int OP_FNMADD   = 14;
  localparam int OP_FNMSUB   = 13;
  localparam int OP_FADD     = 12;
  localparam int OP_FSUB     = 11;
  localparam int OP_FMUL     = 10;
  localparam int OP_FSGNJ    = 9;
  localparam int OP_FCMP     = 8;
  localparam int OP_FMAX     = 7;
  localparam int OP_FCLASS   = 6;
  localparam int OP_FMV_I2F  = 5;
  localparam int OP_FMV_F2I  = 4;
  localparam int OP_FCVT_I2F = 3;
  localparam int OP_FCVT_F2I = 2;
  localparam int OP_FCVT_HI  = 1;
  localparam int OP_FCVT_LO  = 0;

  // Rounding mode encodings
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  localparam logic [2:0] RM_DYN = 3'd7;

  // Exception flag bit positions
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [4:0] FLAGS_NV = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // A resolved rounding mode above RMM (5, 6 or a still-dynamic 7) is illegal
  function automatic logic rm_is_illegal(input logic [2:0] rm);
    return (rm > RM_RMM);
  endfunction

  // Operations whose result is written to the integer register file
  function automatic logic op_int_dest(input logic [OP_W-1:0] op);
    return op[OP_FCMP] | op[OP_FCLASS] | op[OP_FMV_F2I] | op[OP_FCVT_F2I];
  endfunction

endpackage

// File: rtl/fp_fcsr.sv
// Floating-point CSR fields: dynamic rounding mode and sticky exception flags.
// A software write and a retiring instruction in the same cycle merge so the
// retiring instruction's flags are never lost.
module fp_fcsr
  import fp_issue_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       csr_we,
  input  logic [2:0] csr_wfrm,
  input  logic [4:0] csr_wfflags,
  input  logic       acc_en,
  input  logic [4:0] acc_flags,
  output logic [2:0] frm,
  output logic [4:0] fflags
);

  // frm/fflags registers with write/accumulate merge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frm    <= RM_RNE;
      fflags <= 5'd0;
    end else if (csr_we) begin
      frm    <= csr_wfrm;
      fflags <= csr_wfflags | (acc_en ? acc_flags : 5'd0);
    end else if (acc_en) begin
      frm    <= frm;
      fflags <= fflags | acc_flags;
    end else begin
      frm    <= frm;
      fflags <= fflags;
    end
  end

endmodule

// File: rtl/fp_issue_ctrl.sv
// Issue controller in front of fp_unit: accepts one instruction, resolves the
// rounding mode, pulses the unit enable, waits (bounded) for completion and
// hands the captured result to writeback.
module fp_issue_ctrl
  import fp_issue_ctrl_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [31:0]      in_data1,
  input  logic [31:0]      in_data2,
  input  logic [31:0]      in_data3,
  input  logic [1:0]       in_fmt,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic [OP_W-1:0]  fpu_o_op,
  output logic [31:0]      fpu_o_data1,
  output logic [31:0]      fpu_o_data2,
  output logic [31:0]      fpu_o_data3,
  output logic [1:0]       fpu_o_fmt,
  output logic [2:0]       fpu_o_rm,
  output logic             fpu_o_enable,
  input  logic [31:0]      fpu_i_result,
  input  logic [4:0]       fpu_i_flags,
  input  logic             fpu_i_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_int_dest,
  output logic             out_err,
  input  logic             csr_we,
  input  logic [2:0]       csr_wfrm,
  input  logic [4:0]       csr_wfflags,
  output logic [2:0]       fcsr_frm,
  output logic [4:0]       fcsr_fflags
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  // The counter holds (cycles spent in WAIT - 1); the wait ends TIMEOUT cycles after enable
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       rm_res_s;
  logic             accept_s;
  logic             fpu_done_s;
  logic             timeout_s;
  logic             out_hs_s;

  assign in_ready = (state_r == ST_IDLE);

  // Rounding-mode resolution and per-cycle event decode
  always_comb begin
    rm_res_s = in_rm;
    if (in_rm == RM_DYN) begin
      rm_res_s = fcsr_frm;
    end else begin
      rm_res_s = in_rm;
    end
    accept_s   = (state_r == ST_IDLE) && in_valid;
    fpu_done_s = ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) && fpu_i_ready;
    timeout_s  = (state_r == ST_WAIT) && !fpu_i_ready && (cnt_r == CNT_LAST);
    out_hs_s   = (state_r == ST_RESP) && out_ready;
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!in_valid) begin
          state_s = ST_IDLE;
        end else if (rm_is_illegal(rm_res_s)) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (fpu_i_ready) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fpu_done_s || timeout_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Wait-cycle counter: cleared in ISSUE, saturating in WAIT
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_ISSUE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_WAIT) && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // fp_unit bundle and writeback result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fpu_o_op     <= {OP_W{1'b0}};
      fpu_o_data1  <= 32'd0;
      fpu_o_data2  <= 32'd0;
      fpu_o_data3  <= 32'd0;
      fpu_o_fmt    <= 2'd0;
      fpu_o_rm     <= 3'd0;
      fpu_o_enable <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= 32'd0;
      out_flags    <= 5'd0;
      out_tag      <= {TAG_W{1'b0}};
      out_int_dest <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      fpu_o_enable <= 1'b0;
      if (accept_s) begin
        out_tag      <= in_tag;
        out_int_dest <= op_int_dest(in_op);
        if (rm_is_illegal(rm_res_s)) begin
          // Unit is bypassed entirely: respond with an invalid-operation error
          out_valid  <= 1'b1;
          out_err    <= 1'b1;
          out_result <= 32'd0;
          out_flags  <= FLAGS_NV;
        end else begin
          fpu_o_op     <= in_op;
          fpu_o_data1  <= in_data1;
          fpu_o_data2  <= in_data2;
          fpu_o_data3  <= in_data3;
          fpu_o_fmt    <= in_fmt;
          fpu_o_rm     <= rm_res_s;
          fpu_o_enable <= 1'b1;
        end
      end else if (fpu_done_s) begin
        out_valid  <= 1'b1;
        out_err    <= 1'b0;
        out_result <= fpu_i_result;
        out_flags  <= fpu_i_flags;
      end else if (timeout_s) begin
        out_valid  <= 1'b1;
        out_err    <= 1'b1;
        out_result <= 32'd0;
        out_flags  <= 5'd0;
      end else if (out_hs_s) begin
        out_valid <= 1'b0;
        fpu_o_op  <= {OP_W{1'b0}};
      end
    end
  end

  fp_fcsr u_fcsr (
    .clock       (clock),
    .reset       (reset),
    .csr_we      (csr_we),
    .csr_wfrm    (csr_wfrm),
    .csr_wfflags (csr_wfflags),
    .acc_en      (out_hs_s),
    .acc_flags   (out_flags),
    .frm         (fcsr_frm),
    .fflags      (fcsr_fflags)
  );

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Self-checking bench for fp_issue_ctrl. The bench plays the fp_unit and the
// writeback stage; expectations come from a transaction-level model of the
// rounding-mode, error, latency and fflags rules.
module tb_fp_issue_ctrl;

  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 64;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [16:0]      in_op;
  logic [31:0]      in_data1, in_data2, in_data3;
  logic [1:0]       in_fmt;
  logic [2:0]       in_rm;
  logic [TAG_W-1:0] in_tag;
  logic [16:0]      fpu_o_op;
  logic [31:0]      fpu_o_data1, fpu_o_data2, fpu_o_data3;
  logic [1:0]       fpu_o_fmt;
  logic [2:0]       fpu_o_rm;
  logic             fpu_o_enable;
  logic [31:0]      fpu_i_result;
  logic [4:0]       fpu_i_flags;
  logic             fpu_i_ready;
  logic             out_valid, out_ready;
  logic [31:0]      out_result;
  logic [4:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic             out_int_dest, out_err;
  logic             csr_we;
  logic [2:0]       csr_wfrm;
  logic [4:0]       csr_wfflags;
  logic [2:0]       fcsr_frm;
  logic [4:0]       fcsr_fflags;

  int n_checks = 0;
  int n_errors = 0;

  // Reference fcsr contents
  logic [2:0] mdl_frm;
  logic [4:0] mdl_ff;

  typedef struct {
    int          lat;
    int          en_cnt;
    int          en_k;
    bit          timed_out;
    bit          stable;
    bit          out_stable;
    bit          in_ready_low;
    bit          in_ready_after;
    bit          valid_after;
    bit          op_zero_after;
    logic [16:0] op;
    logic [31:0] d1, d2, d3;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  flags;
    logic        err;
    logic        intd;
    logic [4:0]  tag;
  } obs_t;

  fp_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_fmt(in_fmt), .in_rm(in_rm), .in_tag(in_tag),
    .fpu_o_op(fpu_o_op), .fpu_o_data1(fpu_o_data1), .fpu_o_data2(fpu_o_data2),
    .fpu_o_data3(fpu_o_data3), .fpu_o_fmt(fpu_o_fmt), .fpu_o_rm(fpu_o_rm),
    .fpu_o_enable(fpu_o_enable), .fpu_i_result(fpu_i_result),
    .fpu_i_flags(fpu_i_flags), .fpu_i_ready(fpu_i_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_tag(out_tag), .out_int_dest(out_int_dest),
    .out_err(out_err), .csr_we(csr_we), .csr_wfrm(csr_wfrm),
    .csr_wfflags(csr_wfflags), .fcsr_frm(fcsr_frm), .fcsr_fflags(fcsr_fflags)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  // Plain fcsr write while the block is idle
  task automatic csr_write(input logic [2:0] frm, input logic [4:0] ff);
    @(negedge clock);
    csr_we = 1'b1; csr_wfrm = frm; csr_wfflags = ff;
    @(negedge clock);
    csr_we = 1'b0;
    mdl_frm = frm; mdl_ff = ff;
  endtask

  // Drive one instruction through the block, acting as fp_unit and writeback.
  // rdy_dly: cycles after the enable cycle before fpu_i_ready (-1 = never).
  // Returns observations only; callers compare against the model.
  task automatic do_op(input logic [16:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [1:0] fmt, input logic [2:0] rm,
                       input logic [4:0] tag, input int rdy_dly, input logic [31:0] res,
                       input logic [4:0] flg, input int hold, input bit csr_acc,
                       input bit csr_hs, input logic [2:0] wfrm, input logic [4:0] wff,
                       output obs_t o);
    bit have_out;
    int k;
    o = '{default: 0};
    o.stable = 1'b1; o.out_stable = 1'b1; o.in_ready_low = 1'b1; o.en_k = -1;
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clock); k++; end
    if (!in_ready) begin o.timed_out = 1'b1; return; end
    in_valid = 1'b1; in_op = op; in_data1 = a; in_data2 = b; in_data3 = c;
    in_fmt = fmt; in_rm = rm; in_tag = tag;
    csr_we = csr_acc; csr_wfrm = wfrm; csr_wfflags = wff;
    @(negedge clock);
    in_valid = 1'b0; csr_we = 1'b0;
    in_op = 17'($urandom); in_data1 = $urandom; in_data2 = $urandom; in_data3 = $urandom;
    in_fmt = 2'($urandom); in_rm = 3'($urandom); in_tag = 5'($urandom);
    have_out = 1'b0;
    for (k = 0; k < 200 && !have_out; k++) begin
      if (out_valid) begin
        have_out = 1'b1; o.lat = k + 1;
      end else begin
        if (fpu_o_enable) begin
          o.en_cnt++;
          if (o.en_k < 0) begin
            o.en_k = k; o.op = fpu_o_op; o.d1 = fpu_o_data1; o.d2 = fpu_o_data2;
            o.d3 = fpu_o_data3; o.fmt = fpu_o_fmt; o.rm = fpu_o_rm;
          end
        end else if (o.en_k >= 0) begin
          if (fpu_o_op !== o.op || fpu_o_data1 !== o.d1 || fpu_o_data2 !== o.d2 ||
              fpu_o_data3 !== o.d3 || fpu_o_fmt !== o.fmt || fpu_o_rm !== o.rm)
            o.stable = 1'b0;
        end
        if (o.en_k >= 0 && rdy_dly >= 0 && (k - o.en_k) == rdy_dly) begin
          fpu_i_ready = 1'b1; fpu_i_result = res; fpu_i_flags = flg;
        end else begin
          fpu_i_ready = 1'b0; fpu_i_result = $urandom; fpu_i_flags = 5'($urandom);
        end
        @(negedge clock);
      end
    end
    fpu_i_ready = 1'b0;
    if (!have_out) begin o.timed_out = 1'b1; return; end
    o.res = out_result; o.flags = out_flags; o.err = out_err;
    o.intd = out_int_dest; o.tag = out_tag;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      fpu_i_ready = 1'($urandom); fpu_i_result = $urandom; fpu_i_flags = 5'($urandom);
      @(negedge clock);
      if (!out_valid || out_result !== o.res || out_flags !== o.flags || out_err !== o.err ||
          out_tag !== o.tag || out_int_dest !== o.intd)
        o.out_stable = 1'b0;
      if (o.en_k >= 0 && (fpu_o_op !== o.op || fpu_o_data1 !== o.d1 || fpu_o_rm !== o.rm))
        o.stable = 1'b0;
      if (in_ready) o.in_ready_low = 1'b0;
    end
    fpu_i_ready = 1'b0;
    if (in_ready) o.in_ready_low = 1'b0;
    out_ready = 1'b1; csr_we = csr_hs; csr_wfrm = wfrm; csr_wfflags = wff;
    @(negedge clock);
    out_ready = 1'b0; csr_we = 1'b0;
    o.in_ready_after = in_ready; o.valid_after = out_valid;
    o.op_zero_after = (fpu_o_op == 17'd0);
  endtask

  task automatic test_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (fpu_o_enable !== 1'b0) begin n_errors++; $display("FAIL reset_enable: got %b want 0", fpu_o_enable); end
    n_checks++; if (fpu_o_op !== 17'd0) begin n_errors++; $display("FAIL reset_fpu_op: got %h want 0", fpu_o_op); end
    n_checks++; if ({fcsr_frm, fcsr_fflags} !== 8'd0) begin n_errors++; $display("FAIL reset_fcsr: got %h/%h want 0/0", fcsr_frm, fcsr_fflags); end
    n_checks++; if ({out_result, out_flags, out_err} !== 38'd0) begin n_errors++; $display("FAIL reset_out: got %h %h %b want 0", out_result, out_flags, out_err); end
  endtask

  task automatic test_fadd();
    obs_t o;
    do_op(17'h01000, 32'h3F800000, 32'h40000000, 32'h0, 2'd0, 3'd0, 5'd3, 0,
          32'h40400000, 5'd0, 0, 1'b0, 1'b0, 3'd0, 5'd0, o);
    n_checks++; if (o.timed_out) begin n_errors++; $display("FAIL fadd_done: got timeout want response"); end
    n_checks++; if (o.lat !== 2) begin n_errors++; $display("FAIL fadd_latency: got %0d want 2", o.lat); end
    n_checks++; if (o.en_cnt !== 1) begin n_errors++; $display("FAIL fadd_enable_cycles: got %0d want 1", o.en_cnt); end
    n_checks++; if (o.res !== 32'h40400000) begin n_errors++; $display("FAIL fadd_result: got %h want 40400000", o.res); end
    n_checks++; if ({o.flags, o.err, o.intd} !== 7'd0) begin n_errors++; $display("FAIL fadd_flags_err_int: got %b %b %b want 0 0 0", o.flags, o.err, o.intd); end
    n_checks++; if (o.op !== 17'h01000 || o.d1 !== 32'h3F800000 || o.d2 !== 32'h40000000 || o.rm !== 3'd0) begin
      n_errors++; $display("FAIL fadd_bundle: got op=%h d1=%h d2=%h rm=%0d", o.op, o.d1, o.d2, o.rm); end
    n_checks++; if (o.tag !== 5'd3) begin n_errors++; $display("FAIL fadd_tag: got %0d want 3", o.tag); end
  endtask

  task automatic test_fmadd_wait();
    obs_t o;
    do_op(17'h10000, 32'h11111111, 32'h22222222, 32'h33333333, 2'd1, 3'd2, 5'd9, 4,
          32'hCAFEF00D, 5'd0, 3, 1'b0, 1'b0, 3'd0, 5'd0, o);
    n_checks++; if (o.lat !== 6) begin n_errors++; $display("FAIL fmadd_latency: got %0d want 6", o.lat); end
    n_checks++; if (!o.stable) begin n_errors++; $display("FAIL fmadd_fpu_stable: got unstable want stable"); end
    n_checks++; if (!o.out_stable) begin n_errors++; $display("FAIL fmadd_out_stable: got unstable want stable"); end
    n_checks++; if (!o.in_ready_low) begin n_errors++; $display("FAIL fmadd_in_ready_low: got 1 during response want 0"); end
    n_checks++; if (o.in_ready_after !== 1'b1 || o.valid_after !== 1'b0) begin n_errors++; $display("FAIL fmadd_after_hs: got in_ready=%b out_valid=%b want 1 0", o.in_ready_after, o.valid_after); end
    n_checks++; if (o.res !== 32'hCAFEF00D || o.d3 !== 32'h33333333 || o.fmt !== 2'd1) begin n_errors++; $display("FAIL fmadd_data: got res=%h d3=%h fmt=%0d", o.res, o.d3, o.fmt); end
    n_checks++; if (!o.op_zero_after) begin n_errors++; $display("FAIL fmadd_op_zero_idle: got nonzero op want 0"); end
  endtask

  task automatic test_dyn_rm();
    obs_t o;
    csr_write(3'd3, 5'd0);
    do_op(17'h00400, 32'h1, 32'h2, 32'h0, 2'd0, 3'd7, 5'd1, 1, 32'h5, 5'd0, 0,
          1'b0, 1'b0, 3'd0, 5'd0, o);
    n_checks++; if (o.rm !== 3'd3 || o.err !== 1'b0) begin n_errors++; $display("FAIL dyn_rm_resolve: got rm=%0d err=%b want 3 0", o.rm, o.err); end
    csr_write(3'd5, 5'd0);
    do_op(17'h00400, 32'h1, 32'h2, 32'h0, 2'd0, 3'd7, 5'd2, 0, 32'h5, 5'd0, 1,
          1'b0, 1'b0, 3'd0, 5'd0, o);
    n_checks++; if (o.err !== 1'b1 || o.flags !== 5'b10000 || o.res !== 32'd0) begin n_errors++; $display("FAIL dyn_rm_illegal: got err=%b flags=%b res=%h want 1 10000 0", o.err, o.flags, o.res); end
    n_checks++; if (o.en_cnt !== 0) begin n_errors++; $display("FAIL dyn_rm_no_enable: got %0d enables want 0", o.en_cnt); end
    n_checks++; if (o.lat !== 1) begin n_errors++; $display("FAIL dyn_rm_err_latency: got %0d want 1", o.lat); end
    mdl_ff = mdl_ff | 5'b10000;
  endtask

  task automatic test_fflags_acc();
    obs_t o;
    csr_write(3'd0, 5'd0);
    do_op(17'h01000, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 5'd4, 0, 32'h1, 5'b00001, 0,
          1'b0, 1'b0, 3'd0, 5'd0, o);
    n_checks++; if (fcsr_fflags !== 5'b00001) begin n_errors++; $display("FAIL fflags_acc_first: got %b want 00001", fcsr_fflags); end
    do_op(17'h00800, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 5'd5, 2, 32'h2, 5'b00100, 1,
          1'b0, 1'b1, 3'd0, 5'b01000, o);
    n_checks++; if (fcsr_fflags !== 5'b01100) begin n_errors++; $display("FAIL fflags_merge_write: got %b want 01100", fcsr_fflags); end
    mdl_frm = 3'd0; mdl_ff = 5'b01100;
  endtask

  task automatic test_timeout();
    obs_t o;
    do_op(17'h00200, 32'h7, 32'h8, 32'h9, 2'd0, 3'd1, 5'd6, -1, 32'h0, 5'd0, 0,
          1'b0, 1'b0, 3'd0, 5'd0, o);
    n_checks++; if (o.timed_out || (o.lat - 1 - o.en_k) !== TIMEOUT) begin n_errors++; $display("FAIL timeout_latency: got %0d cycles after enable want %0d", o.lat - 1 - o.en_k, TIMEOUT); end
    n_checks++; if (o.err !== 1'b1 || o.res !== 32'd0 || o.flags !== 5'd0) begin n_errors++; $display("FAIL timeout_response: got err=%b res=%h flags=%b want 1 0 0", o.err, o.res, o.flags); end
    n_checks++; if (fcsr_fflags !== mdl_ff) begin n_errors++; $display("FAIL timeout_fflags: got %b want %b", fcsr_fflags, mdl_ff); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [16:0] one;
    logic [16:0] op;
    logic [2:0]  rm, rm_eff, wfrm;
    logic [4:0]  flg, wff, tag, exp_flags;
    logic [31:0] a, b, c, res, exp_res;
    logic        exp_intd;
    bit          ill, acc, hs;
    int          idx, dly, hold, mode;
    one = 17'd1;
    for (int it = 0; it < 24; it++) begin
      idx = int'($urandom_range(16, 2));
      op = (one << idx) | {15'd0, 2'($urandom_range(3, 0))};
      a = $urandom; b = $urandom; c = $urandom; res = $urandom;
      rm = 3'($urandom_range(7, 0)); flg = 5'($urandom); tag = 5'($urandom);
      wfrm = 3'($urandom_range(7, 0)); wff = 5'($urandom);
      dly = int'($urandom_range(5, 0)); hold = int'($urandom_range(3, 0));
      mode = int'($urandom_range(2, 0)); acc = (mode == 1); hs = (mode == 2);
      // Model: dynamic rm uses frm as it stood before any same-cycle write
      rm_eff = (rm == 3'd7) ? mdl_frm : rm;
      ill = (rm_eff >= 3'd5);
      exp_res = ill ? 32'd0 : res;
      exp_flags = ill ? 5'b10000 : flg;
      exp_intd = (idx == 8) || (idx == 6) || (idx == 4) || (idx == 2);
      if (acc) begin mdl_frm = wfrm; mdl_ff = wff; end
      do_op(op, a, b, c, 2'(it), rm, tag, dly, res, flg, hold, acc, hs, wfrm, wff, o);
      if (hs) begin mdl_frm = wfrm; mdl_ff = wff | exp_flags; end
      else mdl_ff = mdl_ff | exp_flags;
      n_checks++; if (o.timed_out || o.lat !== (ill ? 1 : 2 + dly)) begin n_errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, o.lat, ill ? 1 : 2 + dly); end
      n_checks++; if (o.en_cnt !== (ill ? 0 : 1)) begin n_errors++; $display("FAIL rnd%0d_enables: got %0d want %0d", it, o.en_cnt, ill ? 0 : 1); end
      n_checks++; if (o.res !== exp_res || o.flags !== exp_flags || o.err !== ill) begin n_errors++; $display("FAIL rnd%0d_response: got %h %b %b want %h %b %b", it, o.res, o.flags, o.err, exp_res, exp_flags, ill); end
      n_checks++; if (o.intd !== exp_intd || o.tag !== tag) begin n_errors++; $display("FAIL rnd%0d_int_tag: got %b %0d want %b %0d", it, o.intd, o.tag, exp_intd, tag); end
      if (!ill) begin
        n_checks++; if (o.op !== op || o.rm !== rm_eff || o.d1 !== a || o.d2 !== b || o.d3 !== c) begin n_errors++; $display("FAIL rnd%0d_bundle: got op=%h rm=%0d want op=%h rm=%0d", it, o.op, o.rm, op, rm_eff); end
      end
      n_checks++; if (!o.stable || !o.out_stable || !o.in_ready_low || o.in_ready_after !== 1'b1) begin n_errors++; $display("FAIL rnd%0d_handshake: got stable=%b out_stable=%b low=%b after=%b want 1 1 1 1", it, o.stable, o.out_stable, o.in_ready_low, o.in_ready_after); end
      n_checks++; if (fcsr_fflags !== mdl_ff || fcsr_frm !== mdl_frm) begin n_errors++; $display("FAIL rnd%0d_fcsr: got %0d/%b want %0d/%b", it, fcsr_frm, fcsr_fflags, mdl_frm, mdl_ff); end
    end
  endtask

  task automatic test_reset_wait();
    int k;
    csr_write(3'd2, 5'b00110);
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clock); k++; end
    in_valid = 1'b1; in_op = 17'h10000; in_data1 = 32'hDEADBEEF; in_rm = 3'd0;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    n_checks++; if (fpu_o_data1 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rstwait_in_wait: got data1=%h want deadbeef", fpu_o_data1); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({out_valid, fpu_o_enable, fpu_o_op, fpu_o_data1, fpu_o_rm, out_result} !== 87'd0) begin
      n_errors++; $display("FAIL rstwait_outputs: got valid=%b en=%b op=%h d1=%h rm=%0d res=%h want 0", out_valid, fpu_o_enable, fpu_o_op, fpu_o_data1, fpu_o_rm, out_result); end
    n_checks++; if ({fcsr_frm, fcsr_fflags} !== 8'd0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL rstwait_fcsr_idle: got %0d/%b in_ready=%b want 0/0 1", fcsr_frm, fcsr_fflags, in_ready); end
    @(negedge clock);
    reset = 1'b1;
    mdl_frm = 3'd0; mdl_ff = 5'd0;
    @(negedge clock);
    n_checks++; if (in_ready !== 1'b1 || fcsr_fflags !== 5'd0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rstwait_release: got in_ready=%b fflags=%b valid=%b want 1 0 0", in_ready, fcsr_fflags, out_valid); end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_op = 17'd0; in_data1 = 32'd0; in_data2 = 32'd0;
    in_data3 = 32'd0; in_fmt = 2'd0; in_rm = 3'd0; in_tag = 5'd0;
    fpu_i_result = 32'd0; fpu_i_flags = 5'd0; fpu_i_ready = 1'b0; out_ready = 1'b0;
    csr_we = 1'b0; csr_wfrm = 3'd0; csr_wfflags = 5'd0;
    mdl_frm = 3'd0; mdl_ff = 5'd0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_fadd();
    test_fmadd_wait();
    test_dyn_rm();
    test_fflags_acc();
    test_timeout();
    test_random();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
- Sequencing stage directly upstream of fp_unit.
- Accepts one decoded FP instruction per valid/ready handshake and resolves dynamic rounding mode from the local fcsr.frm.
- Drives the fp_unit operand/opcode bundle with a one-cycle enable, holds operands stable until fp_unit reports ready, and captures result and flags.
- Presents the captured result to writeback via valid/ready; accumulates sticky fflags; times out a hung unit.

Parameters:
- TAG_W, 5, width of destination register tag carried alongside the operation.
- TIMEOUT, 64, max cycles waiting for fpu_i_ready after enable before aborting (>=2).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept (state IDLE)
- in_op  in  17  {fmadd,fmsub,fnmadd,fnmsub,fadd,fsub,fmul,fsgnj,fcmp,fmax,fclass,fmv_i2f,fmv_f2i,fcvt_i2f,fcvt_f2i,fcvt_op[1:0]}, bit16..0
- in_data1/in_data2/in_data3  in  32 each  operands
- in_fmt  in  2  format
- in_rm  in  3  instruction rm (3'b111 = dynamic)
- in_tag  in  TAG_W  destination register tag
- fpu_o_op  out  17  to fp_unit op inputs, same bit order
- fpu_o_data1/2/3  out  32 each  to fp_unit operands
- fpu_o_fmt  out  2;  fpu_o_rm  out  3  resolved rm
- fpu_o_enable  out  1  one-cycle start pulse
- fpu_i_result  in  32;  fpu_i_flags  in  5;  fpu_i_ready  in  1  from fp_unit
- out_valid  out  1;  out_ready  in  1  writeback handshake
- out_result  out  32;  out_flags  out  5;  out_tag  out  TAG_W
- out_int_dest  out  1  result targets integer file (fcmp|fclass|fmv_f2i|fcvt_f2i)
- out_err  out  1  illegal rm or timeout; result forced 0
- csr_we  in  1;  csr_wfrm  in  3;  csr_wfflags  in  5  fcsr write
- fcsr_frm  out  3;  fcsr_fflags  out  5  current fcsr fields

Behaviour:
- Reset (reset=0, async): state IDLE; all out_*, fpu_o_*, fcsr_* = 0; timeout counter 0. Reset mid-operation aborts silently; no flags accumulate.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: in_ready=1. On in_valid, latch op/data/fmt/tag and resolve rm: in_rm!=7 -> in_rm; in_rm==7 -> fcsr_frm.
  - Resolved rm in {5,6,7}: go to RESP with out_err=1, result 0, flags 5'b10000 (NV); fp_unit not enabled.
  - Else go to ISSUE.
- ISSUE (one cycle): fpu_o_enable=1; counter cleared. fpu_i_ready=1 -> capture result/flags, go to RESP; else go to WAIT.
- WAIT: fpu_o_enable=0; fpu_o_op/data/fmt/rm held stable. fpu_i_ready=1 -> capture, go to RESP. Counter reaching TIMEOUT-1 without ready -> RESP, out_err=1, result 0, flags 0.
- fpu_o_* are held from ISSUE until the RESP→IDLE transition. fpu_o_op is zeroed in IDLE.
- RESP: out_valid=1; out_* stable until out_ready. On handshake go to IDLE; in_ready rises the next cycle (no same-cycle accept).
- Minimum latency: accept at cycle N, enable at N+1, out_valid at N+2 (ready in enable cycle).
- fflags: on RESP handshake, fcsr_fflags |= out_flags.
  - csr_we in the same cycle: fcsr_fflags = csr_wfflags | out_flags; fcsr_frm = csr_wfrm.
  - csr_we in any other state: plain write.
- Dynamic rm samples fcsr_frm at accept. A same-cycle csr_we does not affect that instruction.
- fpu_i_ready outside ISSUE/WAIT is ignored.
- Counter width: $clog2(TIMEOUT)+1; saturates, never wraps.

Decomposition:
- Shared fp package holds:
  - op-bit index constants (FMADD=16 … FCVT_OP=1:0)
  - rm encodings (RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4, DYN=7)
  - flag bit positions (NV=4, DZ=3, OF=2, UF=1, NX=0)
  - state encoding
- Sub-module: fp_fcsr (frm/fflags registers, write/accumulate merge). FSM and datapath stay in the top.

Test Plan:
- fadd 0x3F800000+0x40000000, rm=0, fpu ready in enable cycle -> out_valid at N+2, result 0x40400000, flags 0, out_int_dest=0, fpu_o_enable high exactly 1 cycle.
- fmadd, fpu ready after 4 WAIT cycles, out_ready low 3 cycles -> fpu_o_data stable throughout, out_result stable until handshake, in_ready=0 until the cycle after.
- fcsr frm=3 via csr_we, then fmul with rm=7 -> fpu_o_rm=3. Then frm=5 and rm=7 -> out_err=1, flags 5'b10000, fpu_o_enable never asserted.
- Two ops returning flags 5'b00001 then 5'b00100, with csr_we fflags=5'b01000 on the second handshake -> fcsr_fflags=5'b01100.
- fpu_i_ready never asserted, TIMEOUT=64 -> out_valid 64 cycles after enable, out_err=1, result 0, fflags unchanged.
- Deassert reset during WAIT -> all outputs 0 immediately, state IDLE, in_ready=1 after release, fflags 0.
